// File: rtl/vme_request_decoder_pkg.sv
// Shared definitions for the VME request decoder: strobe polarity, CPU
// function codes, FSM state encoding, default window bases and the
// address-window decode helper.
package vme_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam logic [7:0]  DEFAULT_A24_BASE = 8'hFF;
    localparam logic [15:0] DEFAULT_A16_BASE = 16'hFFFF;
    localparam logic [1:0]  DEFAULT_A40_BASE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_ACKED     = 2'd2,
        ST_TIMED_OUT = 2'd3
    } state_t;

    // Decoded window, active-high internally; at most one window bit is set.
    typedef struct packed {
        logic hit;
        logic a16;
        logic a24;
        logic a40;
    } window_t;

    // Priority decode A16 > A24 > A40; CPU space (IACK) never hits.
    function automatic window_t decode_window(
        input logic [31:0] addr,
        input logic [2:0]  fc,
        input logic [15:0] a16_base,
        input logic [7:0]  a24_base,
        input logic [1:0]  a40_base
    );
        window_t w;
        w = window_t'(4'b0000);
        if (fc == FC_CPU_SPACE) begin
            w = window_t'(4'b0000);
        end else if (addr[31:16] == a16_base) begin
            w.hit = 1'b1;
            w.a16 = 1'b1;
        end else if (addr[31:24] == a24_base) begin
            w.hit = 1'b1;
            w.a24 = 1'b1;
        end else if (addr[31:30] == a40_base) begin
            w.hit = 1'b1;
            w.a40 = 1'b1;
        end else begin
            w = window_t'(4'b0000);
        end
        return w;
    endfunction

endpackage

// File: rtl/vme_request_decoder_if.sv
// CPU-side bus bundle of the VME request decoder. The master drives the
// 68030 cycle and the sequencer acknowledge; the slave (decoder) drives the
// request strobes and watchdog status.
interface vme_request_decoder_if;

    logic        cpu_as;
    logic [31:0] cpu_address;
    logic [2:0]  cpu_fc;
    logic [1:0]  cpu_dsack;
    logic        cpu_berr;

    logic        request_vme;
    logic        request_vme_a16;
    logic        request_vme_a24;
    logic        request_vme_a40;
    logic        timeout_berr;
    logic [7:0]  timeout_count;
    logic [31:0] timeout_address;

    modport master (
        output cpu_as, cpu_address, cpu_fc, cpu_dsack, cpu_berr,
        input  request_vme, request_vme_a16, request_vme_a24, request_vme_a40,
        input  timeout_berr, timeout_count, timeout_address
    );

    modport slave (
        input  cpu_as, cpu_address, cpu_fc, cpu_dsack, cpu_berr,
        output request_vme, request_vme_a16, request_vme_a24, request_vme_a40,
        output timeout_berr, timeout_count, timeout_address
    );

endinterface

// File: rtl/vme_request_decoder_signal_sync.sv
// Two-flop synchronizer for a single asynchronous control input. Both flops
// reset to RESET_VALUE so an inactive-high strobe reads inactive out of reset.
module signal_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw input through the metastability and output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vme_request_decoder.sv
// VME request decoder: turns a synchronised 68030 address strobe into VME
// window request strobes and runs the bus-timeout watchdog. All outputs come
// straight from flops.
module vme_request_decoder
    import vme_pkg::*;
#(
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]   A24_BASE       = DEFAULT_A24_BASE,
    parameter logic [15:0]  A16_BASE       = DEFAULT_A16_BASE,
    parameter logic [1:0]   A40_BASE       = DEFAULT_A40_BASE
) (
    input  logic                  clock,
    input  logic                  reset,
    vme_request_decoder_if.slave  bus
);

    // Counter value seen on the edge that completes TIMEOUT_CYCLES edges in REQUEST.
    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 32'd1);

    logic    w_as_sync;
    logic    w_as_active;
    logic    w_ack;
    logic    w_terminal;
    window_t w_window;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [31:0] r_address;
    logic [31:0] w_address_next;
    logic        r_request_vme;
    logic        w_request_vme_next;
    logic        r_request_a16;
    logic        w_request_a16_next;
    logic        r_request_a24;
    logic        w_request_a24_next;
    logic        r_request_a40;
    logic        w_request_a40_next;
    logic        r_timeout_berr;
    logic        w_timeout_berr_next;
    logic [7:0]  r_timeout_count;
    logic [7:0]  w_timeout_count_next;
    logic [31:0] r_timeout_address;
    logic [31:0] w_timeout_address_next;

    signal_sync #(
        .RESET_VALUE (1'b1)
    ) u_as_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (bus.cpu_as),
        .o_q   (w_as_sync)
    );

    assign w_window    = decode_window(bus.cpu_address, bus.cpu_fc, A16_BASE, A24_BASE, A40_BASE);
    assign w_as_active = (w_as_sync == ACTIVE);
    assign w_ack       = (bus.cpu_dsack != 2'b11) || (bus.cpu_berr == ACTIVE);
    assign w_terminal  = (r_count == TERMINAL);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next output values; a CPU abort outranks acknowledge and
    // timeout so release timing never stretches, and acknowledge beats timeout.
    always_comb begin
        w_state_next           = r_state;
        w_count_next           = r_count;
        w_address_next         = r_address;
        w_request_vme_next     = r_request_vme;
        w_request_a16_next     = r_request_a16;
        w_request_a24_next     = r_request_a24;
        w_request_a40_next     = r_request_a40;
        w_timeout_berr_next    = r_timeout_berr;
        w_timeout_count_next   = r_timeout_count;
        w_timeout_address_next = r_timeout_address;

        case (r_state)
            ST_IDLE: begin
                w_count_next        = 16'd0;
                w_request_vme_next  = INACTIVE;
                w_request_a16_next  = INACTIVE;
                w_request_a24_next  = INACTIVE;
                w_request_a40_next  = INACTIVE;
                w_timeout_berr_next = INACTIVE;
                if (w_as_active && w_window.hit) begin
                    w_state_next       = ST_REQUEST;
                    w_address_next     = bus.cpu_address;
                    w_request_vme_next = ACTIVE;
                    w_request_a16_next = ~w_window.a16;
                    w_request_a24_next = ~w_window.a24;
                    w_request_a40_next = ~w_window.a40;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_REQUEST: begin
                if (!w_as_active) begin
                    w_state_next       = ST_IDLE;
                    w_count_next       = 16'd0;
                    w_request_vme_next = INACTIVE;
                    w_request_a16_next = INACTIVE;
                    w_request_a24_next = INACTIVE;
                    w_request_a40_next = INACTIVE;
                end else if (w_ack) begin
                    w_state_next = ST_ACKED;
                end else if (w_terminal) begin
                    w_state_next           = ST_TIMED_OUT;
                    w_request_vme_next     = INACTIVE;
                    w_request_a16_next     = INACTIVE;
                    w_request_a24_next     = INACTIVE;
                    w_request_a40_next     = INACTIVE;
                    w_timeout_berr_next    = ACTIVE;
                    w_timeout_address_next = r_address;
                    w_timeout_count_next   = (r_timeout_count == 8'd255) ? 8'd255
                                                                        : r_timeout_count + 8'd1;
                end else begin
                    w_count_next = r_count + 16'd1;
                end
            end

            ST_ACKED: begin
                if (!w_as_active) begin
                    w_state_next       = ST_IDLE;
                    w_request_vme_next = INACTIVE;
                    w_request_a16_next = INACTIVE;
                    w_request_a24_next = INACTIVE;
                    w_request_a40_next = INACTIVE;
                end else begin
                    w_state_next = ST_ACKED;
                end
            end

            ST_TIMED_OUT: begin
                if (!w_as_active) begin
                    w_state_next        = ST_IDLE;
                    w_timeout_berr_next = INACTIVE;
                end else begin
                    w_state_next = ST_TIMED_OUT;
                end
            end

            default: begin
                w_state_next        = ST_IDLE;
                w_count_next        = 16'd0;
                w_request_vme_next  = INACTIVE;
                w_request_a16_next  = INACTIVE;
                w_request_a24_next  = INACTIVE;
                w_request_a40_next  = INACTIVE;
                w_timeout_berr_next = INACTIVE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count           <= 16'd0;
            r_address         <= 32'd0;
            r_request_vme     <= INACTIVE;
            r_request_a16     <= INACTIVE;
            r_request_a24     <= INACTIVE;
            r_request_a40     <= INACTIVE;
            r_timeout_berr    <= INACTIVE;
            r_timeout_count   <= 8'd0;
            r_timeout_address <= 32'd0;
        end else begin
            r_count           <= w_count_next;
            r_address         <= w_address_next;
            r_request_vme     <= w_request_vme_next;
            r_request_a16     <= w_request_a16_next;
            r_request_a24     <= w_request_a24_next;
            r_request_a40     <= w_request_a40_next;
            r_timeout_berr    <= w_timeout_berr_next;
            r_timeout_count   <= w_timeout_count_next;
            r_timeout_address <= w_timeout_address_next;
        end
    end

    assign bus.request_vme     = r_request_vme;
    assign bus.request_vme_a16 = r_request_a16;
    assign bus.request_vme_a24 = r_request_a24;
    assign bus.request_vme_a40 = r_request_a40;
    assign bus.timeout_berr    = r_timeout_berr;
    assign bus.timeout_count   = r_timeout_count;
    assign bus.timeout_address = r_timeout_address;

endmodule

// File: tb/tb_vme_request_decoder.sv
// Self-checking bench for vme_request_decoder: directed vector table, hand
// sequences for reset and saturation, and randomized cycles scored against
// an edge-timeline model of request / timeout behaviour.
module tb_vme_request_decoder;

    localparam int T = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    vme_request_decoder_if u_bus();

    vme_request_decoder #(
        .TIMEOUT_CYCLES (T),
        .A24_BASE       (8'hFF),
        .A16_BASE       (16'hFFFF),
        .A40_BASE       (2'b10)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_bus)
    );

    int checks = 0;
    int errors = 0;
    int model_tc = 0;
    logic [31:0] model_ta = 32'h0;

    logic [4:0] outs;
    assign outs = {u_bus.request_vme, u_bus.request_vme_a16, u_bus.request_vme_a24,
                   u_bus.request_vme_a40, u_bus.timeout_berr};

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  fc;
        int          hold;     // edges AS stays low
        int          d;        // ack seen d edges after request goes active (0 = never)
        int          kind;     // 0:dsack 01 1:dsack 10 2:dsack 00 3:berr
        int          exp_win;  // 0 none, 1 A16, 2 A24, 3 A40
        bit          exp_to;
    } vec_t;

    vec_t vecs[9];

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Window rule straight from the address map.
    function automatic int model_window(input logic [31:0] a, input logic [2:0] fc);
        if (fc == 3'b111) return 0;
        if (a[31:16] == 16'hFFFF) return 1;
        if (a[31:24] == 8'hFF) return 2;
        if (a[31:30] == 2'b10) return 3;
        return 0;
    endfunction

    // One CPU cycle; AS falls before edge 1, outputs are checked after every edge.
    task automatic run_txn(input logic [31:0] addr, input logic [2:0] fc, input int hold,
                           input int d, input int kind, input int exp_win, input bit exp_to,
                           input string name);
        int release_edge;
        int to_edge;
        int req_end;
        logic [4:0] exp;
        release_edge = hold + 3;
        to_edge      = 3 + T;
        req_end      = exp_to ? to_edge : release_edge;
        @(negedge clock);
        u_bus.cpu_address = addr;
        u_bus.cpu_fc      = fc;
        u_bus.cpu_as      = 1'b0;
        for (int e = 1; e <= release_edge + 1; e++) begin
            @(posedge clock);
            #1;
            exp = 5'b11111;
            if (exp_win != 0 && e >= 3 && e < req_end) begin
                exp[4] = 1'b0;
                if (exp_win == 1) exp[3] = 1'b0;
                if (exp_win == 2) exp[2] = 1'b0;
                if (exp_win == 3) exp[1] = 1'b0;
            end
            if (exp_to && e >= to_edge && e < release_edge) exp[0] = 1'b0;
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL %s edge %0d strobes got %b expected %b", name, e, outs, exp);
            end
            @(negedge clock);
            if (e == hold) u_bus.cpu_as = 1'b1;
            if (d > 0 && e == d + 2) begin
                case (kind)
                    0:       u_bus.cpu_dsack = 2'b01;
                    1:       u_bus.cpu_dsack = 2'b10;
                    2:       u_bus.cpu_dsack = 2'b00;
                    default: u_bus.cpu_berr  = 1'b0;
                endcase
            end
        end
        u_bus.cpu_dsack = 2'b11;
        u_bus.cpu_berr  = 1'b1;
        if (exp_to) begin
            model_tc = (model_tc == 255) ? 255 : model_tc + 1;
            model_ta = addr;
        end
        check_val({name, " timeout_count"}, {24'd0, u_bus.timeout_count}, model_tc);
        check_val({name, " timeout_address"}, u_bus.timeout_address, model_ta);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int hold, d, kind, win;
        bit acked, to;

        vecs[0] = '{32'hFF123456, 3'b101, 20, 10, 0, 2, 1'b0}; // A24 read, dsack 01
        vecs[1] = '{32'hFFFF0040, 3'b001, 12,  3, 1, 1, 1'b0}; // A16 priority
        vecs[2] = '{32'h00001000, 3'b101,  8,  0, 0, 0, 1'b0}; // miss
        vecs[3] = '{32'hFFFF0040, 3'b111,  8,  2, 0, 0, 1'b0}; // IACK never hits
        vecs[4] = '{32'h80000000, 3'b110, 25,  0, 0, 3, 1'b1}; // timeout
        vecs[5] = '{32'hBF000000, 3'b101, 25, 16, 2, 3, 1'b0}; // ack on terminal edge
        vecs[6] = '{32'hBF000000, 3'b101, 16,  0, 0, 3, 1'b0}; // abort on terminal edge
        vecs[7] = '{32'hFF000000, 3'b010, 10,  2, 3, 2, 1'b0}; // berr acknowledge
        vecs[8] = '{32'hFFFE0000, 3'b001,  6,  0, 0, 2, 1'b0}; // short cycle, A24

        reset = 1'b0;
        u_bus.cpu_as      = 1'b1;
        u_bus.cpu_address = 32'h0;
        u_bus.cpu_fc      = 3'b000;
        u_bus.cpu_dsack   = 2'b11;
        u_bus.cpu_berr    = 1'b1;

        repeat (3) @(negedge clock);
        check_val("reset strobes", {27'd0, outs}, 32'h1F);
        check_val("reset timeout_count", {24'd0, u_bus.timeout_count}, 32'd0);
        check_val("reset timeout_address", u_bus.timeout_address, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_val("idle strobes", {27'd0, outs}, 32'h1F);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].addr, vecs[i].fc, vecs[i].hold, vecs[i].d, vecs[i].kind,
                    vecs[i].exp_win, vecs[i].exp_to, $sformatf("vec%0d", i));
        end

        // Drive the timeout counter well past saturation.
        for (int i = 0; i < 256; i++) begin
            a = {2'b10, 6'h15, 24'(i)};
            run_txn(a, 3'b101, T + 1, 0, 0, 3, 1'b1, "saturate");
        end
        check_val("saturated count", {24'd0, u_bus.timeout_count}, 32'd255);

        // Reset in the middle of an active request.
        @(negedge clock);
        u_bus.cpu_address = 32'hFF000100;
        u_bus.cpu_fc      = 3'b101;
        u_bus.cpu_as      = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check_val("mid request active", {31'd0, u_bus.request_vme}, 32'd0);
        @(negedge clock);
        reset        = 1'b0;
        u_bus.cpu_as = 1'b1;
        #1;
        check_val("async reset strobes", {27'd0, outs}, 32'h1F);
        check_val("async reset timeout_count", {24'd0, u_bus.timeout_count}, 32'd0);
        check_val("async reset timeout_address", u_bus.timeout_address, 32'd0);
        model_tc = 0;
        model_ta = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        run_txn(32'hFF123456, 3'b101, 20, 10, 0, 2, 1'b0, "post reset ack");
        run_txn(32'h80000000, 3'b110, 25, 0, 0, 3, 1'b1, "post reset timeout");

        // Randomized cycles against the timeline model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = {16'hFFFF, 16'($urandom)};
                1:       a = {8'hFF, 24'($urandom)};
                2:       a = {2'b10, 30'($urandom)};
                default: a = $urandom;
            endcase
            f     = 3'($urandom_range(0, 7));
            hold  = $urandom_range(4, 30);
            d     = $urandom_range(0, 20);
            kind  = $urandom_range(0, 3);
            win   = model_window(a, f);
            acked = (win != 0) && (d > 0) && (d <= T) && (3 + d < hold + 3);
            to    = (win != 0) && !acked && (3 + T < hold + 3);
            run_txn(a, f, hold, d, kind, win, to, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vme_request_decoder.md
# vme_request_decoder

Upstream stage of the VME data-transfer sequencer in the k30p CPU card. It decodes each 68030 bus cycle into VME request strobes (`request_vme`, `request_vme_a16`, `request_vme_a24`, `request_vme_a40`). It also runs the VME bus-timeout watchdog. On timeout it withdraws `request_vme`, which makes the downstream sequencer raise CPU BERR, and it raises its own `timeout_berr` for cycles the sequencer never accepts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: posedges allowed from request to acknowledge; legal range 2..65535.
- `A24_BASE`, default 8'hFF: `cpu_address[31:24]` selecting the A24 window, excluding the A16 window.
- `A16_BASE`, default 16'hFFFF: `cpu_address[31:16]` selecting the A16 window.
- `A40_BASE`, default 2'b10: `cpu_address[31:30]` selecting the A40 window.

Ports:
- `clock` in 1: system clock. All logic on posedge.
- `reset` in 1: reset, asynchronous, active-low.
- `cpu_as` in 1: CPU address strobe, active-low, asynchronous.
- `cpu_address` in 32: CPU address. Stable while `cpu_as` is low.
- `cpu_fc` in 3: CPU function code.
- `cpu_dsack` in 2: acknowledge from the downstream sequencer, active-low.
- `cpu_berr` in 1: bus error from the downstream sequencer, active-low.
- `request_vme` out 1: VME cycle request, active-low.
- `request_vme_a16` out 1: A16 window hit, active-low.
- `request_vme_a24` out 1: A24 window hit, active-low.
- `request_vme_a40` out 1: A40 window hit, active-low.
- `timeout_berr` out 1: watchdog bus error, active-low. ORed into CPU BERR at top level.
- `timeout_count` out 8: saturating count of timeouts.
- `timeout_address` out 32: address of the most recent timed-out cycle.

## Operation
- `cpu_as` passes through a 2-flop synchronizer to give `as_sync`. Address and FC are sampled raw, only on the IDLE→REQUEST edge.
- **Window decode**, in priority order:
  - A16 when `[31:16]==A16_BASE`.
  - Else A24 when `[31:24]==A24_BASE`.
  - Else A40 when `[31:30]==A40_BASE`.
  - Else no hit.
- `cpu_fc==3'b111` (CPU space/IACK) is never a hit.
- **State machine:**
  - IDLE: all request outputs inactive, counter cleared. When `as_sync` is active and the decode hits, go to REQUEST. Register the window strobe(s) and assert `request_vme`. A miss stays in IDLE.
  - REQUEST: counter increments each edge.
    - Any `cpu_dsack` bit active or `cpu_berr` active → go to ACKED; counter freezes.
    - Else, when counter reaches `TIMEOUT_CYCLES` → go to TIMED_OUT. Deassert `request_vme` and all window strobes, assert `timeout_berr`, latch `timeout_address`, increment `timeout_count` (saturating at 255).
    - `as_sync` inactive → go to IDLE and deassert all requests (CPU abort).
  - ACKED: hold requests. When `as_sync` is inactive → go to IDLE and deassert all requests.
  - TIMED_OUT: hold `timeout_berr` active. When `as_sync` is inactive → go to IDLE and release it. A cycle never re-requests after a timeout.
- **Simultaneous events:**
  - Acknowledge and counter terminal on the same edge: acknowledge wins, no timeout.
  - `as_sync` inactive and terminal on the same edge: go to IDLE, no timeout recorded.
- **Reset, including mid-cycle:**
  - State IDLE; `request_vme`, all window strobes and `timeout_berr` = 1.
  - `timeout_count` = 0; `timeout_address` = 0.

## Timing
- `request_vme` and the window strobe go active on the 3rd posedge after `cpu_as` falls (2 sync + 1 state). Window strobes and `request_vme` change on the same edge.
- Timeout: `request_vme` goes inactive exactly `TIMEOUT_CYCLES` posedges after it went active. `timeout_berr` goes active on that same edge.
- Release: requests and `timeout_berr` go inactive on the 3rd posedge after `cpu_as` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `vme_pkg`:
  - constants ACTIVE/INACTIVE;
  - FC codes (`FC_CPU_SPACE`=3'b111);
  - state encoding;
  - default window bases.
- Sub-module `signal_sync`: 2-flop synchronizer with parameterized reset value of 1. Instantiated for `cpu_as`.

## Test plan
- A24 read: addr FF123456, fc 101, `cpu_dsack`=01 after 10 cycles. Required: `request_vme`/`request_vme_a24` low on the 3rd edge; other strobes high; release 3 edges after AS rises; `timeout_count` stays 0.
- A16 priority: addr FFFF0040, fc 001. Required: only `request_vme_a16` low.
- Miss and IACK: addr 00001000, then addr FFFF0040 with fc 111. Required: no request strobe ever goes low.
- Timeout: `TIMEOUT_CYCLES`=16, addr 80000000, no dsack. Required: `request_vme` high after exactly 16 edges; `timeout_berr` low until AS rises; `timeout_count`=1; `timeout_address`=80000000.
- Race: dsack asserted on the terminal edge. Required: no timeout, `timeout_count` unchanged. Then 256 timeouts; required: `timeout_count` stays at 255.
- Reset mid-REQUEST: all outputs 1 and counters 0 asynchronously. The next AS proceeds normally.
